// File: rtl/pmaxpool_if.sv
// Stream interface for the max-pool stage: the upstream pixel-vector stream
// (input side) and the pooled-vector stream with its frame-end flag (output side).
interface pmaxpool_if #(
  parameter int N       = 16,
  parameter int CHANNEL = 32
);
  logic                   input_vld;
  logic [CHANNEL*N-1:0]   input_din;
  logic [CHANNEL*N-1:0]   pool_dout;
  logic                   pool_dout_vld;
  logic                   pool_dout_end;

  // Producer side: drives pixels, observes pooled results.
  modport master (
    output input_vld, input_din,
    input  pool_dout, pool_dout_vld, pool_dout_end
  );

  // Pooling stage side.
  modport slave (
    input  input_vld, input_din,
    output pool_dout, pool_dout_vld, pool_dout_end
  );
endinterface

// File: rtl/pmaxpool.sv
// Channel-parallel 2x2 stride-2 max pooling over a raster-order stream of
// CHANNEL x N-bit signed pixel vectors. Horizontal pairs are reduced into
// h_q / the line buffer on even rows; odd rows combine with the stored pair
// and emit one pooled vector per 2x2 window, one cycle after its last pixel.
module pmaxpool #(
  parameter int N          = 16,
  parameter int CHANNEL    = 32,
  parameter int INPUT_SIZE = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  pmaxpool_if.slave  bus
);

  localparam int W    = CHANNEL * N;
  localparam int HALF = INPUT_SIZE / 2;
  localparam int CW   = (INPUT_SIZE > 2) ? $clog2(INPUT_SIZE) : 1;
  localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

  // Position within the frame, horizontal-pair holding register, outputs.
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [W-1:0]  h_q, h_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          end_q, end_d;

  // One horizontally-reduced vector per window column, produced on even rows.
  logic [W-1:0]  linebuf_q [HALF];

  logic          clear;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic [LW-1:0] lb_idx;
  logic [W-1:0]  h_max;
  logic [W-1:0]  win_max;

  // Lane-wise signed maximum; equal operands make the tie choice irrelevant.
  function automatic logic [W-1:0] vmax(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = b;
    for (int i = 0; i < CHANNEL; i++) begin
      if ($signed(a[i*N +: N]) > $signed(b[i*N +: N])) r[i*N +: N] = a[i*N +: N];
    end
    return r;
  endfunction

  assign clear    = rst | ~ce;
  assign accept   = bus.input_vld & ~clear;
  assign col_last = (col_q == LAST);
  assign row_last = (row_q == LAST);
  assign lb_idx   = LW'(col_q >> 1);
  assign h_max    = vmax(h_q, bus.input_din);
  assign win_max  = vmax(linebuf_q[lb_idx], h_max);

  // Next-state: advance raster position and datapath on each accepted beat.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // (an unassigned path would infer a latch).
    col_d  = col_q;
    row_d  = row_q;
    h_d    = h_q;
    dout_d = dout_q;
    vld_d  = 1'b0;
    end_d  = end_q;
    if (accept) begin
      end_d = row_last && col_last;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) begin
        h_d = bus.input_din;
      end else if (row_q[0]) begin
        dout_d = win_max;
        vld_d  = 1'b1;
      end
    end
  end

  // State register with synchronous clear (reset or ce low).
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst || !ce) begin
      col_q  <= '0;
      row_q  <= '0;
      h_q    <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      end_q  <= 1'b1;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      h_q    <= h_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      end_q  <= end_d;
    end
  end

  // Line buffer write on the odd column of even rows.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; each entry is written on an even row before the
    // odd row reads it, so clearing it would only cost logic.
    if (accept && col_q[0] && !row_q[0]) begin
      linebuf_q[lb_idx] <= h_max;
    end
  end

  assign bus.pool_dout     = dout_q;
  assign bus.pool_dout_vld = vld_q;
  assign bus.pool_dout_end = end_q;

endmodule

// File: tb/tb_pmaxpool.sv
// Self-checking bench for pmaxpool (INPUT_SIZE=4, CHANNEL=2, N=16).
// Expected pooled vectors are computed from the accepted pixels and queued
// when the completing beat is driven; a negedge monitor pops and compares.
module tb_pmaxpool;

  localparam int N  = 16;
  localparam int CH = 2;
  localparam int S  = 4;
  localparam int W  = N * CH;

  logic clk;
  logic rst;
  logic ce;

  pmaxpool_if #(.N(N), .CHANNEL(CH)) bus ();

  pmaxpool #(.N(N), .CHANNEL(CH), .INPUT_SIZE(S)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc++;

  // Model state
  logic [W-1:0] pix [S*S];      // pixels accepted in the current frame
  logic [W-1:0] frm [S*S];      // stimulus frame for run_frame
  int           k = 0;          // raster index of next accepted beat
  logic         exp_end = 1'b1;
  logic [W-1:0] last_dout = '0;

  // Scoreboard and observation queues
  logic [W-1:0] exp_q [$];
  int           due_q [$];
  logic [W-1:0] obs_q [$];
  bit           obs_end_q [$];

  function automatic logic [N-1:0] smax(input logic [N-1:0] a, input logic [N-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic logic [W-1:0] win(input int kk);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      r[c*N +: N] = smax(smax(pix[kk][c*N +: N], pix[kk-1][c*N +: N]),
                         smax(pix[kk-S][c*N +: N], pix[kk-S-1][c*N +: N]));
    end
    return r;
  endfunction

  // One clock of stimulus; model updated just after the capturing edge.
  task automatic cycle(input bit rst_v, input bit ce_v, input bit vld_v, input logic [W-1:0] din);
    rst = rst_v;
    ce  = ce_v;
    bus.input_vld = vld_v;
    bus.input_din = din;
    @(posedge clk);
    #1;
    if (rst_v || !ce_v) begin
      k = 0;
      exp_end = 1'b1;
      last_dout = '0;
    end else if (vld_v) begin
      pix[k] = din;
      if (((k / S) % 2 == 1) && (k % 2 == 1)) begin
        exp_q.push_back(win(k));
        due_q.push_back(cyc);
      end
      exp_end = (k == S*S - 1);
      k = (k + 1) % (S*S);
    end
  endtask

  // Monitor: vld timing, data, hold behaviour and frame-end flag every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.pool_dout_vld === 1'b1) begin
        obs_q.push_back(bus.pool_dout);
        obs_end_q.push_back(bus.pool_dout_end);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_vld cyc=%0d dout=%h", cyc, bus.pool_dout);
        end else begin
          last_dout = exp_q.pop_front();
          checks++;
          if (due_q[0] != cyc) begin
            errors++;
            $display("FAIL vld_timing got cyc=%0d expected cyc=%0d", cyc, due_q[0]);
          end
          void'(due_q.pop_front());
        end
      end else if (bus.pool_dout_vld !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL vld_x got %b expected 0/1", bus.pool_dout_vld);
      end else if (exp_q.size() > 0 && due_q[0] <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_vld cyc=%0d expected dout=%h", cyc, exp_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      checks++;
      if (bus.pool_dout !== last_dout) begin
        errors++;
        $display("FAIL dout cyc=%0d got %h expected %h", cyc, bus.pool_dout, last_dout);
      end
      checks++;
      if (bus.pool_dout_end !== exp_end) begin
        errors++;
        $display("FAIL end_flag cyc=%0d got %b expected %b", cyc, bus.pool_dout_end, exp_end);
      end
    end
  end

  function automatic logic [W-1:0] pk(input int c0, input int c1);
    logic [N-1:0] a;
    logic [N-1:0] b;
    a = N'(c0);
    b = N'(c1);
    return {b, a};
  endfunction

  task automatic run_frame(input bit gap);
    for (int i = 0; i < S*S; i++) begin
      cycle(1'b0, 1'b1, 1'b1, frm[i]);
      if (gap) cycle(1'b0, 1'b1, 1'b0, W'($urandom));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, W'($urandom));
  endtask

  task automatic drain_check(input string name);
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d expected 0", name, exp_q.size());
      exp_q.delete();
      due_q.delete();
    end
  endtask

  // Checks the four pooled vectors of the ramp frame (ch0=k, ch1=-k).
  task automatic check_ramp(input string name, input int first, input int base);
    int e0 [4];
    int e1 [4];
    e0 = '{5, 7, 13, 15};
    e1 = '{0, -2, -8, -10};
    checks++;
    if (obs_q.size() < first + 4) begin
      errors++;
      $display("FAIL %s_count got %0d expected %0d", name, obs_q.size(), first + 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[first+i] !== pk(base + e0[i], e1[i])) begin
          errors++;
          $display("FAIL %s_val%0d got %h expected %h", name, i, obs_q[first+i], pk(base + e0[i], e1[i]));
        end
      end
    end
  endtask

  task automatic ramp(input int base);
    for (int i = 0; i < S*S; i++) frm[i] = pk(base + i, -i);
  endtask

  task automatic check_idle_state(input string name);
    @(negedge clk);
    checks++;
    if (bus.pool_dout_vld !== 1'b0 || bus.pool_dout !== '0 || bus.pool_dout_end !== 1'b1) begin
      errors++;
      $display("FAIL %s got vld=%b dout=%h end=%b expected vld=0 dout=0 end=1",
               name, bus.pool_dout_vld, bus.pool_dout, bus.pool_dout_end);
    end
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b0, '0);
    mon_en = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, W'($urandom));
    check_idle_state("reset_state");
  endtask

  task automatic test_frame();
    obs_q.delete();
    obs_end_q.delete();
    ramp(0);
    cycle(1'b0, 1'b1, 1'b1, frm[0]);
    @(negedge clk);
    checks++;
    if (bus.pool_dout_end !== 1'b0) begin
      errors++;
      $display("FAIL end_fall got %b expected 0", bus.pool_dout_end);
    end
    for (int i = 1; i < S*S; i++) cycle(1'b0, 1'b1, 1'b1, frm[i]);
    drain_check("frame");
    check_ramp("frame", 0, 0);
    checks++;
    if (obs_end_q.size() != 4 || obs_end_q[3] !== 1'b1 || obs_end_q[0] !== 1'b0) begin
      errors++;
      $display("FAIL frame_end_at_vld got n=%0d expected end only with 4th vld", obs_end_q.size());
    end
  endtask

  task automatic test_gapped();
    obs_q.delete();
    ramp(0);
    run_frame(1'b1);
    drain_check("gapped");
    check_ramp("gapped", 0, 0);
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL gapped_npulses got %0d expected 4", obs_q.size());
    end
  endtask

  task automatic test_signed();
    obs_q.delete();
    for (int i = 0; i < S*S; i++) frm[i] = W'($urandom);
    frm[0][15:0] = 16'h8000; frm[1][15:0] = 16'h7FFF;
    frm[4][15:0] = 16'hFFFF; frm[5][15:0] = 16'h0000;
    frm[0][31:16] = 16'h8000; frm[1][31:16] = 16'h8000;
    frm[4][31:16] = 16'h8000; frm[5][31:16] = 16'h8000;
    frm[2][31:16] = 16'hFFFE; frm[3][31:16] = 16'hFFFF;
    frm[6][31:16] = 16'hFFFD; frm[7][31:16] = 16'h8001;
    run_frame(1'b0);
    drain_check("signed");
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL signed_count got %0d expected 4", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0][15:0] !== 16'h7FFF) begin
        errors++;
        $display("FAIL signed_mixed got %h expected 7fff", obs_q[0][15:0]);
      end
      checks++;
      if (obs_q[0][31:16] !== 16'h8000) begin
        errors++;
        $display("FAIL signed_allmin got %h expected 8000", obs_q[0][31:16]);
      end
      checks++;
      if (obs_q[1][31:16] !== 16'hFFFF) begin
        errors++;
        $display("FAIL signed_neg got %h expected ffff", obs_q[1][31:16]);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_q.delete();
    obs_end_q.delete();
    ramp(0);
    run_frame(1'b0);
    ramp(100);
    run_frame(1'b0);
    drain_check("b2b");
    check_ramp("b2b_f1", 0, 0);
    check_ramp("b2b_f2", 4, 100);
    checks++;
    if (obs_end_q.size() != 8 || obs_end_q[3] !== 1'b1 || obs_end_q[4] !== 1'b0 || obs_end_q[7] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end got n=%0d expected end high only at vld 4 and 8", obs_end_q.size());
    end
  endtask

  task automatic test_reset_mid();
    ramp(0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, frm[i]);
    cycle(1'b1, 1'b1, 1'b1, frm[6]);
    check_idle_state("rst_mid_state");
    obs_q.delete();
    run_frame(1'b0);
    drain_check("rst_mid");
    check_ramp("rst_mid", 0, 0);
  endtask

  task automatic test_ce_mid();
    ramp(0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1, frm[i]);
    cycle(1'b0, 1'b0, 1'b1, frm[10]);
    cycle(1'b0, 1'b0, 1'b1, frm[11]);
    check_idle_state("ce_mid_state");
    obs_q.delete();
    run_frame(1'b0);
    drain_check("ce_mid");
    check_ramp("ce_mid", 0, 0);
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL ce_mid_npulses got %0d expected 4", obs_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
    bus.input_vld = 1'b0;
    bus.input_din = '0;
    test_reset();
    test_frame();
    test_gapped();
    test_signed();
    test_back_to_back();
    test_reset_mid();
    test_ce_mid();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
